// File: rtl/bcd_digit_entry.sv
// Collects up to four ASCII decimal digits into BCD registers and hands them to bcd2bin.
// Define BCD_ENTRY_BACKSPACE_EN to make 8'h08 remove the last digit instead of being rejected.
module bcd_digit_entry #(
  parameter logic [7:0] ENTER_CODE = 8'h0D,
  parameter logic [7:0] CLEAR_CODE = 8'h1B
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done_tick,
  input  logic       i_conv_ready,
  input  logic       i_conv_done_tick,
  output logic       o_start,
  output logic [3:0] o_bcd3,
  output logic [3:0] o_bcd2,
  output logic [3:0] o_bcd1,
  output logic [3:0] o_bcd0,
  output logic [2:0] o_digit_cnt,
  output logic       o_busy,
  output logic       o_err_tick,
  output logic [1:0] o_state
);

  // Converter handshake: in LAUNCH, a cycle with i_conv_ready high yields a single
  // o_start pulse next cycle; digits then stay frozen until i_conv_done_tick in WAIT.
  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_bcd3, r_bcd2, r_bcd1, r_bcd0;
  logic [2:0] r_cnt;
  logic       r_start, r_busy, r_err;

  state_t     w_state_nxt;
  logic [3:0] w_bcd3_nxt, w_bcd2_nxt, w_bcd1_nxt, w_bcd0_nxt;
  logic [2:0] w_cnt_nxt;
  logic       w_start_nxt, w_busy_nxt, w_err_nxt;
  logic       w_is_digit;

  assign w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_ENTRY;
      r_bcd3  <= 4'd0;
      r_bcd2  <= 4'd0;
      r_bcd1  <= 4'd0;
      r_bcd0  <= 4'd0;
      r_cnt   <= 3'd0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcd3  <= w_bcd3_nxt;
      r_bcd2  <= w_bcd2_nxt;
      r_bcd1  <= w_bcd1_nxt;
      r_bcd0  <= w_bcd0_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bcd3_nxt  = r_bcd3;
    w_bcd2_nxt  = r_bcd2;
    w_bcd1_nxt  = r_bcd1;
    w_bcd0_nxt  = r_bcd0;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (i_rx_done_tick) begin
          if (w_is_digit) begin
            if (r_cnt < 3'd4) begin
              w_bcd3_nxt = r_bcd2;
              w_bcd2_nxt = r_bcd1;
              w_bcd1_nxt = r_bcd0;
              w_bcd0_nxt = i_rx_data[3:0];
              w_cnt_nxt  = r_cnt + 3'd1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (i_rx_data == ENTER_CODE) begin
            if (r_cnt != 3'd0) w_state_nxt = ST_LAUNCH;
            else               w_err_nxt   = 1'b1;
          end else if (i_rx_data == CLEAR_CODE) begin
            w_bcd3_nxt = 4'd0;
            w_bcd2_nxt = 4'd0;
            w_bcd1_nxt = 4'd0;
            w_bcd0_nxt = 4'd0;
            w_cnt_nxt  = 3'd0;
`ifdef BCD_ENTRY_BACKSPACE_EN
          end else if (i_rx_data == 8'h08) begin
            if (r_cnt != 3'd0) begin
              w_bcd0_nxt = r_bcd1;
              w_bcd1_nxt = r_bcd2;
              w_bcd2_nxt = r_bcd3;
              w_bcd3_nxt = 4'd0;
              w_cnt_nxt  = r_cnt - 3'd1;
            end else begin
              w_err_nxt = 1'b1;
            end
`endif
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        w_err_nxt = i_rx_done_tick;
        if (i_conv_ready) begin
          w_start_nxt = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_err_nxt = i_rx_done_tick;
        if (i_conv_done_tick) begin
          w_bcd3_nxt  = 4'd0;
          w_bcd2_nxt  = 4'd0;
          w_bcd1_nxt  = 4'd0;
          w_bcd0_nxt  = 4'd0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = ST_ENTRY;
        end
      end
      default: w_state_nxt = ST_ENTRY;
    endcase
    w_busy_nxt = (w_state_nxt != ST_ENTRY);
  end

  assign o_start     = r_start;
  assign o_bcd3      = r_bcd3;
  assign o_bcd2      = r_bcd2;
  assign o_bcd1      = r_bcd1;
  assign o_bcd0      = r_bcd0;
  assign o_digit_cnt = r_cnt;
  assign o_busy      = r_busy;
  assign o_err_tick  = r_err;
  assign o_state     = r_state;

endmodule

// File: doc/bcd_digit_entry.md
# bcd_digit_entry

Upstream feeder for the `bcd2bin` converter. Accepts ASCII decimal characters from the UART receiver, one per `rx_done_tick`, and assembles up to four BCD digits, most-significant first. On carriage return it waits for the converter's `ready`, issues a one-cycle `start`, and holds the digits stable until the converter's `done_tick`. It then clears and accepts the next number.

## Interface
- `ENTER_CODE`, default 8'h0D: character that launches a conversion.
- `CLEAR_CODE`, default 8'h1B: character that discards the digits entered so far.
- `clk`  in  1: single system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: ASCII character; valid only while `rx_done_tick` = 1.
- `rx_done_tick`  in  1: one-cycle strobe for a received character.
- `conv_ready`  in  1: converter `ready`.
- `conv_done_tick`  in  1: converter `done_tick`.
- `start`  out  1: registered one-cycle pulse to converter `start`.
- `bcd3`, `bcd2`, `bcd1`, `bcd0`  out  4 each: digit registers, to converter `bcd3..bcd0`. `bcd0` is the least-significant digit.
- `digit_cnt`  out  3: number of digits held, 0 to 4.
- `busy`  out  1: high in LAUNCH and WAIT.
- `err_tick`  out  1: registered one-cycle pulse for a rejected character.

## Operation
- FSM states: ENTRY, LAUNCH, WAIT.
- Reset: state ENTRY; all `bcd*` = 0; `digit_cnt` = 0; `start`, `busy`, `err_tick` = 0.
- ENTRY, `rx_data` in 8'h30–8'h39, `digit_cnt` < 4:
  - shift left: `bcd3` ← `bcd2`, `bcd2` ← `bcd1`, `bcd1` ← `bcd0`, `bcd0` ← `rx_data[3:0]`;
  - `digit_cnt` increments.
- ENTRY, digit with `digit_cnt` = 4: digits and count unchanged; `err_tick` pulses (overflow).
- ENTRY, `ENTER_CODE`:
  - `digit_cnt` ≥ 1: go to LAUNCH;
  - `digit_cnt` = 0: `err_tick` pulses; stay in ENTRY.
- ENTRY, `CLEAR_CODE`: all `bcd*` ← 0, `digit_cnt` ← 0; no error.
- ENTRY, any other code: `err_tick` pulses; digits unchanged.
- LAUNCH: on a cycle with `conv_ready` = 1, `start` is 1 in the next cycle and state goes to WAIT. Otherwise stay in LAUNCH indefinitely.
- WAIT, `conv_done_tick` = 1: all `bcd*` ← 0, `digit_cnt` ← 0, state goes to ENTRY.
- `rx_done_tick` in LAUNCH or WAIT: character dropped; `err_tick` pulses. Digits stay frozen.
- `conv_done_tick` outside WAIT: ignored.
- Unused digit positions read 0. Entering "19" gives `bcd1` = 1, `bcd0` = 9, `bcd3` = `bcd2` = 0.

## Timing
- Character tick at edge n: digits, count, state and `err_tick` update at edge n+1.
- `ENTER_CODE` tick at edge n: state is LAUNCH after edge n+1.
  - If `conv_ready` = 1, `start` is high from edge n+2 to edge n+3. Minimum latency is 2 cycles.
- `start` is never high for more than one cycle, and never high twice per launch.
- `bcd*` are stable from entry to LAUNCH until the edge that samples `conv_done_tick`.
- `busy` = 1 exactly while state is LAUNCH or WAIT. It is registered, consistent with state.
- Reset asserted in any state (including mid-WAIT) returns everything to reset values at the next edge. A pending `start` is cancelled.
- `reset` and `rx_done_tick` in the same cycle: reset wins; the character is lost.

## Configuration
- Macro `BCD_ENTRY_BACKSPACE_EN`.
- Defined: 8'h08 in ENTRY undoes one digit.
  - shift right: `bcd0` ← `bcd1`, `bcd1` ← `bcd2`, `bcd2` ← `bcd3`, `bcd3` ← 0;
  - `digit_cnt` decrements;
  - with `digit_cnt` = 0, `err_tick` pulses and nothing changes.
- Undefined: 8'h08 is an ordinary invalid code (`err_tick`, no change). No backspace logic is present.

## Test plan
- Send "1", "9", 8'h0D with `conv_ready` = 1:
  - `bcd1:bcd0` = 1:9, `bcd3:bcd2` = 0:0, `digit_cnt` = 2;
  - `start` pulses once, 2 cycles after the 8'h0D tick;
  - `conv_done_tick` → all digits 0, `digit_cnt` = 0, `busy` = 0.
- Send "1","2","3","4","5": the 5th tick gives `err_tick`; digits remain 1,2,3,4 (`bcd3`..`bcd0`).
- Send 8'h0D with `digit_cnt` = 0 → `err_tick` = 1, no `start`. Send "A" → `err_tick` = 1.
- Send "7", 8'h0D with `conv_ready` = 0 for 10 cycles, then 1:
  - `start` comes one cycle after `conv_ready` rises;
  - a "3" sent during WAIT is dropped with `err_tick`, and `bcd0` stays 7.
- Send "5", "6", assert `reset` for 1 cycle mid-WAIT → all outputs 0, state ENTRY. Send "8", 8'h1B → digits cleared.
- Backspace:
  - with `BCD_ENTRY_BACKSPACE_EN`: "4","2",8'h08 → `bcd0` = 4, `digit_cnt` = 1;
  - without it: the same sequence → `err_tick`, `bcd1:bcd0` = 4:2.
